profile_session_ctrl: RTL and testbench

- Session sequencer for the CPU access-profiling histogram.
- Takes host commands from the debug bridge and drives the profiler's run gate (prof_active) and its clear request.
- Enforces an optional capture window counted in CPU clkena strobes, with optional external-trigger arming.
- Serialises the histogram RAM, followed by a window/cycle summary word, onto a valid/ready stream back to the bridge.

---
 rtl/profile_pkg.sv | 25 ++
 rtl/profile_dump_seq.sv | 96 +++++++++
 rtl/profile_session_ctrl.sv | 147 ++++++++++++++
 tb/tb_profile_session_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/profile_pkg.sv
// profile_pkg: shared opcodes, state encoding and default sizes for the
// profiling session controller and its dump engine.
package profile_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_CNT_W  = 32;

    localparam logic [7:0] OP_STOP   = 8'h00;
    localparam logic [7:0] OP_START  = 8'h01;
    localparam logic [7:0] OP_DUMP   = 8'h02;
    localparam logic [7:0] OP_ARM    = 8'h03;
    localparam logic [7:0] OP_WINDOW = 8'h04;
    localparam logic [7:0] OP_CLEAR  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_ARMED    = 3'd2,
        ST_RUN      = 3'd3,
        ST_DUMP_RD  = 3'd4,
        ST_DUMP_OUT = 3'd5,
        ST_DUMP_SUM = 3'd6
    } state_t;

endpackage

// File: rtl/profile_dump_seq.sv
// profile_dump_seq: reads every histogram word in address order, streams
// each one on a valid/ready port, then appends the cycle-count summary word
// flagged as last. Started by a one-cycle i_start; o_done marks the final
// transfer so the controller can return to idle on the same edge.
module profile_dump_seq
    import profile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_cycles,
    output logic              o_done,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ack,
    input  logic [31:0]       i_rd_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_data,
    output logic              o_last
);

    state_t              r_phase;
    logic                r_rd_req;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_valid;
    logic [31:0]         r_data;
    logic                r_last;
    logic [ADDR_W-1:0]   w_addr_max;

    assign w_addr_max = {ADDR_W{1'b1}};

    // Read / stream / summary sequencing; reset drops request and valid at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase  <= ST_IDLE;
            r_rd_req <= 1'b0;
            r_addr   <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_last   <= 1'b0;
        end else begin
            case (r_phase)
                ST_IDLE: begin
                    if (i_start) begin
                        r_phase  <= ST_DUMP_RD;
                        r_addr   <= '0;
                        r_rd_req <= 1'b1;
                    end
                end
                ST_DUMP_RD: begin
                    if (i_rd_ack) begin
                        r_data   <= i_rd_data;
                        r_rd_req <= 1'b0;
                        r_valid  <= 1'b1;
                        r_phase  <= ST_DUMP_OUT;
                    end
                end
                ST_DUMP_OUT: begin
                    if (i_ready) begin
                        if (r_addr == w_addr_max) begin
                            // Last RAM word gone: valid stays up for the summary.
                            r_data  <= 32'(i_cycles);
                            r_last  <= 1'b1;
                            r_phase <= ST_DUMP_SUM;
                        end else begin
                            r_addr   <= r_addr + 1'b1;
                            r_rd_req <= 1'b1;
                            r_valid  <= 1'b0;
                            r_phase  <= ST_DUMP_RD;
                        end
                    end
                end
                ST_DUMP_SUM: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_phase <= ST_IDLE;
                    end
                end
                default: r_phase <= ST_IDLE;
            endcase
        end
    end

    assign o_done    = (r_phase == ST_DUMP_SUM) && i_ready;
    assign o_rd_req  = r_rd_req;
    assign o_rd_addr = r_addr;
    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_last    = r_last;

endmodule

// File: rtl/profile_session_ctrl.sv
// profile_session_ctrl: host-command session sequencer for the access-profiling
// histogram. Gates the profiler (prof_active), requests clears, enforces an
// optional clkena-counted capture window and hands dumps to profile_dump_seq.
// Optional feature macro PROFILE_SESSION_AUTODUMP_EN: when defined, window
// expiry starts a dump directly instead of returning to idle.
module profile_session_ctrl
    import profile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_code,
    input  logic [23:0]       cmd_arg,
    input  logic              trig,
    input  logic              clkena,
    output logic              prof_active,
    output logic              prof_clear,
    input  logic              clear_done,
    output logic              hist_rd_req,
    output logic [ADDR_W-1:0] hist_rd_addr,
    input  logic              hist_rd_ack,
    input  logic [31:0]       hist_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              busy
);

    // ST_DUMP_RD stands for the whole dump; the engine tracks the sub-phases.
    state_t             r_state;
    state_t             w_next;
    logic               r_cmd_ready;
    logic               r_prof_active;
    logic               r_prof_clear;
    logic [CNT_W-1:0]   r_window;
    logic [CNT_W-1:0]   r_cycles;
    logic [CNT_W-1:0]   w_cycles_inc;
    logic [31:0]        w_arg32;
    logic               w_cmd_fire;
    logic               w_expire;
    logic               w_zero;
    logic               w_dump_start;
    logic               w_dump_done;

    assign w_cmd_fire   = cmd_valid && r_cmd_ready;
    assign w_arg32      = {8'd0, cmd_arg};
    assign w_cycles_inc = (r_cycles == {CNT_W{1'b1}}) ? r_cycles : r_cycles + 1'b1;
    assign w_expire     = (r_state == ST_RUN) && clkena && (r_window != '0) &&
                          (w_cycles_inc == r_window);

    // Next-state: state-driven transitions first, accepted commands override.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR:   if (clear_done) w_next = ST_IDLE;
            ST_ARMED:   if (trig) w_next = ST_RUN;
            ST_RUN: begin
                if (w_expire) begin
`ifdef PROFILE_SESSION_AUTODUMP_EN
                    w_next = ST_DUMP_RD;
`else
                    w_next = ST_IDLE;
`endif
                end
            end
            ST_DUMP_RD: if (w_dump_done) w_next = ST_IDLE;
            default: ;
        endcase
        if (w_cmd_fire) begin
            case (cmd_code)
                OP_STOP:  w_next = ST_IDLE;
                OP_START: w_next = ST_RUN;
                OP_DUMP:  w_next = ST_DUMP_RD;
                OP_ARM:   w_next = ST_ARMED;
                OP_CLEAR: w_next = ST_CLEAR;
                default: ;
            endcase
        end
    end

    // Entering RUN (trigger or START) or restarting with START clears the count.
    assign w_zero       = (w_next == ST_RUN) &&
                          ((r_state != ST_RUN) || (w_cmd_fire && cmd_code == OP_START));
    assign w_dump_start = (w_next == ST_DUMP_RD) && (r_state != ST_DUMP_RD);

    // State and registered control outputs, all derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_prof_active <= 1'b0;
            r_prof_clear  <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cmd_ready   <= (w_next == ST_IDLE) || (w_next == ST_ARMED) || (w_next == ST_RUN);
            r_prof_active <= (w_next == ST_RUN);
            r_prof_clear  <= w_cmd_fire && (cmd_code == OP_CLEAR);
        end
    end

    // Window register and saturating clkena cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_window <= '0;
            r_cycles <= '0;
        end else begin
            if (w_cmd_fire && cmd_code == OP_WINDOW) begin
                r_window <= w_arg32[CNT_W-1:0];
            end
            if (w_zero) begin
                r_cycles <= '0;
            end else if (r_state == ST_RUN && clkena) begin
                r_cycles <= w_cycles_inc;
            end
        end
    end

    profile_dump_seq #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_dump (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_dump_start),
        .i_cycles  (r_cycles),
        .o_done    (w_dump_done),
        .o_rd_req  (hist_rd_req),
        .o_rd_addr (hist_rd_addr),
        .i_rd_ack  (hist_rd_ack),
        .i_rd_data (hist_rd_data),
        .o_valid   (out_valid),
        .i_ready   (out_ready),
        .o_data    (out_data),
        .o_last    (out_last)
    );

    assign cmd_ready   = r_cmd_ready;
    assign prof_active = r_prof_active;
    assign prof_clear  = r_prof_clear;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_profile_session_ctrl.sv
// tb_profile_session_ctrl: directed session sequence with a stream scoreboard,
// a latency-2 histogram RAM model and a toggling stream sink.
module tb_profile_session_ctrl;

    localparam int AW = 3;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_code = 8'h00;
    logic [23:0]   cmd_arg = 24'h0;
    logic          trig = 1'b0;
    logic          clkena = 1'b0;
    logic          prof_active;
    logic          prof_clear;
    logic          clear_done = 1'b0;
    logic          hist_rd_req;
    logic [AW-1:0] hist_rd_addr;
    logic          hist_rd_ack = 1'b0;
    logic [31:0]   hist_rd_data = 32'h0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic          out_last;
    logic          busy;

    typedef struct packed { logic [31:0] d; logic l; } word_t;
    word_t exp_q[$];
    word_t e;

    int total = 0;
    int bad = 0;
    int rx = 0;
    int lat = 0;
    logic rdy_toggle = 1'b0;
    logic rdy_hold = 1'b0;
    logic stall = 1'b0;
    logic [31:0] held_d;
    logic held_l;

    profile_session_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_arg(cmd_arg), .trig(trig), .clkena(clkena),
        .prof_active(prof_active), .prof_clear(prof_clear), .clear_done(clear_done),
        .hist_rd_req(hist_rd_req), .hist_rd_addr(hist_rd_addr), .hist_rd_ack(hist_rd_ack),
        .hist_rd_data(hist_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] code, input logic [23:0] arg);
        int n = 0;
        cmd_code  = code;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk1("cmd_accept", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_dump(input logic [31:0] summary);
        word_t w;
        for (int i = 0; i < 8; i++) begin
            w.d = 32'h100 + i;
            w.l = 1'b0;
            exp_q.push_back(w);
        end
        w.d = summary;
        w.l = 1'b1;
        exp_q.push_back(w);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        chk1("dump_in_budget", (n < bound), 1'b1);
    endtask

    // RAM model: ack two cycles after a request is seen, data = addr + 0x100.
    always @(posedge clk) begin
        #1;
        if (!hist_rd_req || hist_rd_ack) begin
            lat = 0;
            hist_rd_ack = 1'b0;
        end else begin
            lat++;
            if (lat == 2) begin
                hist_rd_ack  = 1'b1;
                hist_rd_data = 32'h100 + {29'd0, hist_rd_addr};
                lat = 0;
            end
        end
    end

    // Stream sink: alternate ready each cycle, or hold a fixed level.
    always @(posedge clk) begin
        #1;
        if (rdy_toggle) out_ready = ~out_ready;
        else out_ready = rdy_hold;
    end

    // Stream monitor: pop on transfer, hold-check while stalled.
    always @(negedge clk) begin
        if (reset) begin
            stall = 1'b0;
        end else if (out_valid) begin
            if (stall) begin
                chk32("hold_data", out_data, held_d);
                chk1("hold_last", out_last, held_l);
            end
            if (out_ready) begin
                stall = 1'b0;
                rx++;
                if (exp_q.size() == 0) begin
                    chk1("extra_word", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk32("word", out_data, e.d);
                    chk1("word_last", out_last, e.l);
                end
            end else begin
                stall  = 1'b1;
                held_d = out_data;
                held_l = out_last;
            end
        end else begin
            stall = 1'b0;
        end
    end

    initial begin
        int busycnt;
        int pulses;
        int k;
        int actcnt;
        int errs;
        int n;
        int vcount;

        // Reset state
        repeat (3) tick();
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk1("rst_active", prof_active, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_rd_req", hist_rd_req, 1'b0);
        chk1("rst_clear", prof_clear, 1'b0);
        reset = 1'b0;
        tick();
        chk1("idle_cmd_ready", cmd_ready, 1'b1);

        // CLEAR with clear_done after ten cycles
        send_cmd(8'hFF, 24'h0);
        busycnt = 0;
        pulses  = 0;
        for (int i = 1; i <= 11; i++) begin
            if (busy) busycnt++;
            if (prof_clear) pulses++;
            if (i == 11) clear_done = 1'b1;
            tick();
            clear_done = 1'b0;
        end
        chk32("clear_busy_cycles", busycnt, 32'd11);
        chk32("clear_pulses", pulses, 32'd1);
        chk1("clear_idle", busy, 1'b0);
        chk1("clear_cmd_ready", cmd_ready, 1'b1);

        // ARM, then trig together with STOP: STOP wins
        send_cmd(8'h03, 24'h0);
        chk1("armed_busy", busy, 1'b1);
        chk1("armed_inactive", prof_active, 1'b0);
        repeat (5) tick();
        trig = 1'b1;
        cmd_code = 8'h00;
        cmd_valid = 1'b1;
        tick();
        trig = 1'b0;
        cmd_valid = 1'b0;
        chk1("trigstop_idle", busy, 1'b0);
        chk1("trigstop_inactive", prof_active, 1'b0);
        tick();
        chk1("trigstop_inactive2", prof_active, 1'b0);

        // ARM then trig alone: RUN on the next cycle
        send_cmd(8'h03, 24'h0);
        chk1("arm2_inactive", prof_active, 1'b0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk1("trig_run", prof_active, 1'b1);
        send_cmd(8'h00, 24'h0);
        chk1("stop_inactive", prof_active, 1'b0);
        chk1("stop_idle", busy, 1'b0);

        // Window of 5 clkena strobes, one strobe every third cycle
        send_cmd(8'h04, 24'd5);
        chk1("window_no_state", busy, 1'b0);
        send_cmd(8'h01, 24'h0);
        chk1("start_active", prof_active, 1'b1);
        k = 0;
        actcnt = 0;
        errs = 0;
        for (int c = 0; c < 30; c++) begin
            clkena = ((c % 3) == 2);
            if (clkena) k++;
            tick();
            if (prof_active !== (k < 5)) errs++;
            if (prof_active) actcnt++;
        end
        clkena = 1'b0;
        chk32("window_active_errs", errs, 32'd0);
        chk32("window_active_cycles", actcnt, 32'd14);
        chk1("window_idle", busy, 1'b0);

        // Full dump with a toggling sink; summary word is the run count
        push_dump(32'd5);
        rdy_toggle = 1'b1;
        rx = 0;
        send_cmd(8'h02, 24'h0);
        chk1("dump_req_first", hist_rd_req, 1'b1);
        chk32("dump_addr_first", {29'd0, hist_rd_addr}, 32'd0);
        wait_idle(600);
        chk32("dump_words", rx, 32'd9);
        chk32("dump_q_empty", exp_q.size(), 32'd0);
        chk1("dump_idle_valid", out_valid, 1'b0);

        // Reset during DUMP_OUT at address 4
        rdy_toggle = 1'b0;
        rdy_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.d = 32'h100 + i;
            e.l = 1'b0;
            exp_q.push_back(e);
        end
        send_cmd(8'h02, 24'h0);
        n = 0;
        while (!(hist_rd_req && hist_rd_addr == 3'd4) && n < 200) begin
            tick();
            n++;
        end
        rdy_hold = 1'b0;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk1("abort_valid_before", out_valid, 1'b1);
        chk32("abort_addr", {29'd0, hist_rd_addr}, 32'd4);
        reset = 1'b1;
        #1;
        chk1("abort_valid", out_valid, 1'b0);
        chk1("abort_rd_req", hist_rd_req, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk32("abort_q_empty", exp_q.size(), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // New dump restarts at address 0; counter was reset
        push_dump(32'd0);
        rdy_toggle = 1'b1;
        rx = 0;
        send_cmd(8'h02, 24'h0);
        chk32("restart_addr", {29'd0, hist_rd_addr}, 32'd0);
        wait_idle(600);
        chk32("restart_words", rx, 32'd9);

        // Window expiry with window = 3
        rx = 0;
        send_cmd(8'h04, 24'd3);
`ifdef PROFILE_SESSION_AUTODUMP_EN
        push_dump(32'd3);
`endif
        send_cmd(8'h01, 24'h0);
        for (int c = 0; c < 6; c++) begin
            clkena = ((c % 2) == 1);
            tick();
        end
        clkena = 1'b0;
`ifdef PROFILE_SESSION_AUTODUMP_EN
        wait_idle(600);
        chk32("autodump_words", rx, 32'd9);
`else
        vcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid || hist_rd_req) vcount++;
            tick();
        end
        chk32("no_autodump_traffic", vcount, 32'd0);
        chk32("no_autodump_words", rx, 32'd0);
`endif
        chk1("expiry_idle", busy, 1'b0);
        chk1("expiry_inactive", prof_active, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
